// File: rtl/unpacked_array_pkg.sv
// Shared constants and helpers for the multi-channel unpacked-array FIFO.
// No logic; elaboration-time only.
// Not applicable (no handshake in a package).
package unpacked_array_pkg;

    // Default geometry: two channels of bytes, four entries deep.
    localparam int DEF_M     = 2;
    localparam int DEF_W     = 8;
    localparam int DEF_DEPTH = 4;

    // Width needed to hold an occupancy value from 0 up to and including depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/unpacked_array_fifo_mem.sv
// Flop-based storage: DEPTH entries, each holding M words of W bits.
// Write lands on the rising edge; read is asynchronous (zero-cycle).
// No flow control here; the caller gates the write enable.
module unpacked_array_fifo_mem
    import unpacked_array_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEF_DEPTH)
) (
    input  logic          clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i [M],
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o [M]
);

    // Storage array; deliberately not reset so it maps to plain flops.
    logic [W-1:0] mem_q [DEPTH][M];

    // Write all channels of the addressed entry together.
    always_ff @(posedge clock) begin
        if (we_i) begin
            for (int i = 0; i < M; i++) begin
                mem_q[waddr_i][i] <= wdata_i[i];
            end
        end
    end

    // Asynchronous read of the addressed entry, one word per channel.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            rdata_o[i] = mem_q[raddr_i][i];
        end
    end

endmodule

// File: rtl/unpacked_array_fifo.sv
// Multi-channel FIFO with shared pointers and first-word-fall-through read.
// Push edge to rd_valid is one cycle; rd_data follows the head combinationally.
// wr_ready/rd_valid come from registered occupancy only; writes while full are dropped and flagged.
module unpacked_array_fifo
    import unpacked_array_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                            clock,
    input  logic                            rstn,
    input  logic                            flush,
    input  logic                            ch_en    [M],
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [W-1:0]                    wr_data  [M],
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [W-1:0]                    rd_data  [M],
    output logic [count_width(DEPTH)-1:0]   count,
    output logic                            overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic          push;
    logic          pop;
    logic          full;
    logic          mem_we;
    logic [W-1:0]  wr_word [M];

    // Handshake decode from registered occupancy only, so neither ready nor
    // valid depends combinationally on the opposite side's request.
    always_comb begin
        full     = (count_q == FULL_CNT);
        wr_ready = !full;
        rd_valid = (count_q != '0);
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
        // A flush discards the cycle's traffic, so keep the memory untouched too.
        mem_we   = push && !flush;
    end

    // Disabled channels store zero rather than whatever is on their data lines.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            wr_word[i] = ch_en[i] ? wr_data[i] : '0;
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer roll-over is the wrap.
            if (push) begin
                wr_ptr_d = wr_ptr_q + ONE_PTR;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ONE_PTR;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
            // A write offered while full is lost; remember that it happened.
            if (wr_valid && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    unpacked_array_fifo_mem #(
        .M     (M),
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_unpacked_array_fifo.sv
module tb_unpacked_array_fifo;

    localparam int M     = 2;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef logic [M-1:0][W-1:0] entry_t;

    logic         clock;
    logic         rstn;
    logic         flush;
    logic         ch_en    [M];
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] wr_data  [M];
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data  [M];
    logic [2:0]   count;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model: a plain queue of entries plus a sticky flag.
    entry_t mq[$];
    bit     movf = 0;

    unpacked_array_fifo #(.M(M), .W(W), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .rstn     (rstn),
        .flush    (flush),
        .ch_en    (ch_en),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the FIFO rules.
    always @(posedge clock or negedge rstn) begin
        int     n;
        entry_t e;
        if (!rstn) begin
            mq.delete();
            movf = 0;
        end else if (flush) begin
            mq.delete();
            movf = 0;
        end else begin
            n = mq.size();
            if (wr_valid && n == DEPTH) movf = 1;
            if (rd_ready && n > 0) void'(mq.pop_front());
            if (wr_valid && n < DEPTH) begin
                for (int i = 0; i < M; i++) e[i] = ch_en[i] ? wr_data[i] : '0;
                mq.push_back(e);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_count", 32'(count), 32'(mq.size()));
            check("cmp_rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
            check("cmp_wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
            check("cmp_overflow", 32'(overflow), 32'(movf));
            if (mq.size() != 0) begin
                for (int i = 0; i < M; i++)
                    check("cmp_rd_data", 32'(rd_data[i]), 32'(mq[0][i]));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [7:0] a, input logic [7:0] b);
        wr_valid   = v;
        wr_data[0] = a;
        wr_data[1] = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; flush = 1'b0; rd_ready = 1'b0;
        ch_en[0] = 1'b1; ch_en[1] = 1'b1;
        set_wr(1'b0, 8'h00, 8'h00);
        repeat (2) tick();
        check("rst_count", 32'(count), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        rstn = 1'b1;
        chk_en = 1;
        tick();

        // Two pushes, then drain.
        set_wr(1'b1, 8'h11, 8'h22); tick();
        check("basic_count1", 32'(count), 1);
        check("basic_head0", 32'(rd_data[0]), 32'h11);
        check("basic_head1", 32'(rd_data[1]), 32'h22);
        set_wr(1'b1, 8'h33, 8'h44); tick();
        check("basic_count2", 32'(count), 2);
        set_wr(1'b0, 8'h00, 8'h00); rd_ready = 1'b1; tick();
        check("basic_count3", 32'(count), 1);
        check("basic_next0", 32'(rd_data[0]), 32'h33);
        check("basic_next1", 32'(rd_data[1]), 32'h44);
        tick();
        check("basic_count4", 32'(count), 0);
        rd_ready = 1'b0;

        // Fill, overflow attempt, drain original contents.
        for (int k = 0; k < 4; k++) begin
            set_wr(1'b1, 8'(8'h10 + k), 8'(8'h20 + k)); tick();
        end
        set_wr(1'b1, 8'hAA, 8'hBB); tick();
        check("ovf_wr_ready", 32'(wr_ready), 0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 4);
        set_wr(1'b0, 8'h00, 8'h00); rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain0", 32'(rd_data[0]), 32'(8'h10 + k));
            check("ovf_drain1", 32'(rd_data[1]), 32'(8'h20 + k));
            tick();
        end
        rd_ready = 1'b0;
        check("ovf_empty", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Steady push+pop at occupancy two; pointers wrap.
        set_wr(1'b1, 8'h40, 8'h50); tick();
        set_wr(1'b1, 8'h41, 8'h51); tick();
        rd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_wr(1'b1, 8'(8'h42 + k), 8'(8'h52 + k));
            check("wrap_head", 32'(rd_data[0]), 32'(8'h40 + k));
            tick();
            check("wrap_count", 32'(count), 2);
        end
        set_wr(1'b0, 8'h00, 8'h00);
        check("wrap_tail0", 32'(rd_data[0]), 32'h46); tick();
        check("wrap_tail1", 32'(rd_data[1]), 32'h57); tick();
        rd_ready = 1'b0;

        // Channel mask: channel 1 disabled stores zero.
        ch_en[0] = 1'b1; ch_en[1] = 1'b0;
        set_wr(1'b1, 8'h5A, 8'hC3); tick();
        set_wr(1'b0, 8'h00, 8'h00);
        ch_en[1] = 1'b1;
        check("mask_ch0", 32'(rd_data[0]), 32'h5A);
        check("mask_ch1", 32'(rd_data[1]), 32'h00);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;

        // Flush overrides a write and clears the sticky flag.
        for (int k = 0; k < 5; k++) begin
            set_wr(1'b1, 8'(8'h60 + k), 8'(8'h70 + k)); tick();
        end
        set_wr(1'b0, 8'h00, 8'h00); rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check("fl_pre_count", 32'(count), 3);
        check("fl_pre_ovf", 32'(overflow), 1);
        check("fl_pre_head", 32'(rd_data[0]), 32'h61);
        flush = 1'b1; set_wr(1'b1, 8'h77, 8'h77); tick();
        flush = 1'b0; set_wr(1'b0, 8'h00, 8'h00);
        check("fl_count", 32'(count), 0);
        check("fl_ovf", 32'(overflow), 0);
        check("fl_rd_valid", 32'(rd_valid), 0);

        // Asynchronous reset mid-cycle with two entries held.
        set_wr(1'b1, 8'h81, 8'h82); tick();
        set_wr(1'b1, 8'h83, 8'h84); tick();
        set_wr(1'b0, 8'h00, 8'h00);
        check("ar_pre_count", 32'(count), 2);
        #2 rstn = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_rd_valid", 32'(rd_valid), 0);
        check("ar_wr_ready", 32'(wr_ready), 1);
        #3 rstn = 1'b1;
        tick();
        set_wr(1'b1, 8'h01, 8'h02); tick();
        set_wr(1'b0, 8'h00, 8'h00);
        check("ar_post_count", 32'(count), 1);
        check("ar_post0", 32'(rd_data[0]), 32'h01);
        check("ar_post1", 32'(rd_data[1]), 32'h02);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        tick();
        check("end_count", 32'(count), 0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unpacked_array_fifo.md
UNPACKED_ARRAY_FIFO -- requirements
Module: unpacked_array_fifo

Interface
REQ-001 Parameter M, default 2: number of channels; every per-channel port is an unpacked array sized [M].
REQ-002 Parameter W, default 8: bit width of each channel word.
REQ-003 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-004 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rstn  input  1: reset, asynchronous, active-low.
REQ-006 Port flush  input  1: synchronous clear of FIFO contents.
REQ-007 Port ch_en  input  logic ch_en [M]: per-channel write enable mask.
REQ-008 Port wr_valid  input  1: write request.
REQ-009 Port wr_ready  output  1: FIFO can accept a write.
REQ-010 Port wr_data  input  logic [W-1:0] wr_data [M]: write word for each channel.
REQ-011 Port rd_valid  output  1: head entry available.
REQ-012 Port rd_ready  input  1: consumer accepts head entry.
REQ-013 Port rd_data  output  logic [W-1:0] rd_data [M]: head entry, one word per channel.
REQ-014 Port count  output  $clog2(DEPTH+1): number of occupied entries.
REQ-015 Port overflow  output  1: sticky flag, set by a write attempted while full.

Function
REQ-016 Push when wr_valid && wr_ready; pop when rd_valid && rd_ready; all M channels share one write pointer and one read pointer.
REQ-017 On push, channel i stores wr_data[i] if ch_en[i]=1, else stores all-zero.
REQ-018 wr_ready = (count != DEPTH); rd_valid = (count != 0); both decoded from registered state, with no combinational path from wr_valid or rd_ready.
REQ-019 rd_data is first-word-fall-through: rd_data[i] = mem[rd_ptr][i]; latency is push edge to rd_valid=1 in the following cycle.
REQ-020 Push and pop in the same cycle leave count unchanged; both pointers advance.
REQ-021 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-022 count increments by 1 on push only, decrements by 1 on pop only, and never exceeds DEPTH or drops below 0.
REQ-023 wr_valid=1 while count==DEPTH sets overflow; the write is discarded and memory is unchanged.
REQ-024 overflow clears only on reset or flush.
REQ-025 flush=1 sets pointers=0, count=0 and overflow=0 at the next edge; flush overrides any push or pop in that cycle.
REQ-026 rd_data is don't-care when rd_valid=0; the bench shall not check it.

Reset
REQ-027 rstn=0 asynchronously forces pointers=0, count=0, overflow=0, hence wr_ready=1 and rd_valid=0.
REQ-028 Memory contents are not reset.
REQ-029 Reset asserted mid-burst discards all entries; the first push after rstn deassertion lands in entry 0.

Structure
REQ-030 Package unpacked_array_pkg holds the default M, W and DEPTH constants and a count-width function, clog2(DEPTH+1).
REQ-031 Storage is the single sub-module unpacked_array_fifo_mem: DEPTH x [M] x W, one write port, one asynchronous read port, unpacked-array ports.
REQ-032 All state is flop-based so the block can be triplicated directly.

Verification
REQ-033 M=2, W=8, DEPTH=4: push {8'h11,8'h22} then {8'h33,8'h44}, rd_ready=1 -> rd_data {11,22} then {33,44}; count 1,2,1,0.
REQ-034 Push 4 entries, then wr_valid=1 with {AA,BB} -> wr_ready=0, overflow=1, count=4; drain returns the original 4 entries, with no AA/BB.
REQ-035 count=2 plus simultaneous push and pop for 6 cycles -> count stays 2, pointers wrap, data order preserved.
REQ-036 ch_en={1,0}, push {8'h5A,8'hC3} -> rd_data {5A,00}.
REQ-037 count=3 with overflow=1, then flush with wr_valid=1 -> next cycle count=0, overflow=0, rd_valid=0.
REQ-038 rstn pulsed low mid-cycle with count=2 -> count=0 immediately without a clock edge; after release, push {01,02} -> rd_data {01,02}.
